// File: rtl/clock_set_ctrl.sv
// Mode/enable sequencer for the clock digit chain: RUN ripple, SET field editing, and blink blanking.
// Optional auto-repeat of btn_inc while editing is enabled by defining CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl #(
    parameter int BLINK_HALF   = 25_000_000
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       done_sec,
    input  logic       done_min,
    input  logic       done_hour,
    output logic       en_sec,
    output logic       en_min,
    output logic       en_hour,
    output logic       carry_day,
    output logic [1:0] mode,
    output logic [2:0] blank
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_SET_HOUR = 2'd1;
    localparam logic [1:0] ST_SET_MIN  = 2'd2;
    localparam logic [1:0] ST_SET_SEC  = 2'd3;

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

    logic [1:0]    r_state;
    logic          r_btn_mode_q;
    logic          r_btn_inc_q;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic [2:0]    r_blank;

    logic w_mode_press;
    logic w_inc_press;
    logic w_in_set;
    logic w_inc_pulse;
    logic w_edit_pulse;

    assign w_mode_press = btn_mode & ~r_btn_mode_q;
    assign w_inc_press  = btn_inc & ~r_btn_inc_q;
    assign w_in_set     = (r_state != ST_RUN);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] REP_ONE = RW'(1);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_armed;
    logic          w_rep_fire;

    // r_rep_cnt == 0 means idle; only a real press starts it, so a button held while entering SET never repeats.
    assign w_rep_fire = w_in_set & btn_inc & ~w_inc_press & (r_rep_cnt != '0) &
                        (r_rep_armed ? (r_rep_cnt == RW'(REPEAT_RATE))
                                     : (r_rep_cnt == RW'(REPEAT_DELAY)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (!w_in_set || !btn_inc || w_mode_press) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_inc_press || w_rep_fire) begin
            r_rep_cnt   <= REP_ONE;
            r_rep_armed <= w_rep_fire;
        end else if (r_rep_cnt != '0) begin
            r_rep_cnt   <= r_rep_cnt + REP_ONE;
        end
    end

    assign w_inc_pulse = (w_inc_press & w_in_set) | w_rep_fire;
`else
    assign w_inc_pulse = w_inc_press & w_in_set;
`endif

    // A mode press in the same cycle swallows the edit pulse.
    assign w_edit_pulse = w_inc_pulse & ~w_mode_press;

    always_comb begin
        en_sec    = 1'b0;
        en_min    = 1'b0;
        en_hour   = 1'b0;
        carry_day = 1'b0;
        case (r_state)
            ST_RUN: begin
                en_sec    = tick;
                en_min    = done_sec;
                en_hour   = done_min;
                carry_day = done_hour;
            end
            ST_SET_HOUR: en_hour = w_edit_pulse;
            ST_SET_MIN:  en_min  = w_edit_pulse;
            ST_SET_SEC:  en_sec  = w_edit_pulse;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_RUN;
            r_btn_mode_q <= 1'b1;
            r_btn_inc_q  <= 1'b1;
        end else begin
            r_btn_mode_q <= btn_mode;
            r_btn_inc_q  <= btn_inc;
            if (w_mode_press) begin
                r_state <= r_state + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_mode_press || w_inc_pulse) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blank <= 3'b000;
        end else begin
            case (r_state)
                ST_SET_HOUR: r_blank <= {r_phase, 2'b00};
                ST_SET_MIN:  r_blank <= {1'b0, r_phase, 1'b0};
                ST_SET_SEC:  r_blank <= {2'b00, r_phase};
                default:     r_blank <= 3'b000;
            endcase
        end
    end

    assign mode  = r_state;
    assign blank = r_blank;

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode and enable sequencer for the clock's digit-counter chain (seconds, minutes, hours, day carry). In RUN it forwards the 1 Hz tick into the seconds stage and ripples each stage's `done` into the next stage's `enable`. In SET modes it freezes the chain, steers debounced button presses to one selected field, and drives per-field blanking so the field being edited blinks on the 7-segment display.

## Interface
- `BLINK_HALF`, default 25_000_000: clk cycles per blink half-period.
- `REPEAT_DELAY`, default 25_000_000: clk cycles of `btn_inc` hold before the first auto-repeat (only with the macro).
- `REPEAT_RATE`, default 5_000_000: clk cycles between auto-repeats (only with the macro).
- `clk`, input, 1: system clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `tick`, input, 1: one-cycle 1 Hz pulse.
- `btn_mode`, input, 1: debounced, synchronous level; the rising edge advances the mode.
- `btn_inc`, input, 1: debounced, synchronous level; the rising edge increments the selected field.
- `done_sec`, `done_min`, `done_hour`, input, 1 each: stage terminal outputs. Each is high when its count is at max and its enable is high.
- `en_sec`, `en_min`, `en_hour`, output, 1 each: stage enables (combinational).
- `carry_day`, output, 1: day-increment pulse for downstream stages (combinational).
- `mode`, output, 2: current state encoding.
- `blank`, output, 3: display blanking mask {hour, min, sec} (registered).

## Operation
- **States:** RUN=2'd0, SET_HOUR=2'd1, SET_MIN=2'd2, SET_SEC=2'd3.
- **Mode cycle:** a `mode_press` advances RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- **Press detection:** `mode_press = btn_mode & ~btn_mode_q` and `inc_press = btn_inc & ~btn_inc_q`. Both `_q` registers reset to 1, so a button held across reset produces no press.
- **RUN:**
  - `en_sec = tick`, `en_min = done_sec`, `en_hour = done_min`, `carry_day = done_hour`.
  - `inc_press` is ignored.
- **SET_x:**
  - Only the selected field's enable equals `inc_pulse`. All other enables and `carry_day` are 0.
  - `tick` is ignored, so the clock is stopped.
  - Carries are not propagated: the selected field wraps at its maximum without bumping the next field.
  - Without the macro, `inc_pulse = inc_press`.
- **Simultaneous mode and inc press:** `mode_press` wins. No enable is asserted that cycle.
- **Blink:**
  - A counter runs 0..BLINK_HALF-1. `phase` toggles when it wraps.
  - The counter clears to 0 and `phase` clears to 0 (visible) on any `mode_press` or `inc_pulse`.
  - In SET_x, the `blank` bit of the selected field equals `phase` and the other bits are 0. In RUN, `blank` = 3'b000.
- **Reset values:**
  - State = RUN, `mode` = 0, `blank` = 0, `phase` = 0, blink counter = 0, repeat counter = 0.
  - Enables follow the combinational equations. With `tick` and `done_*` low, all enables are 0.

## Timing
- Enables are combinational from the state register and the inputs. They are valid in the same cycle as `tick`, `done_*` or the press edge, so the counters sample them at the next rising edge.
- A press is sampled in cycle k (input high, `_q` low). An `inc_press` produces `en_*` high in cycle k only. A `mode_press` updates state and `mode` at edge k+1, and the new routing applies from cycle k+1.
- A held button generates exactly one press until it is released (input low for at least 1 cycle).
- `blank` updates one cycle after `phase` or state changes.
- Asserting `reset_n` mid-SET returns to RUN immediately (asynchronously). The counter values themselves are untouched by this block.

## Configuration
- **`CLOCK_SET_AUTO_REPEAT_EN` defined:**
  - In SET_x, while `btn_inc` stays high, a repeat counter starts at the press.
  - An extra `inc_pulse` fires after REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
  - Each repeat pulse also restarts the blink counter.
  - The repeat counter clears on release, on `mode_press`, and in RUN.
- **Not defined:** one pulse per press. The repeat logic and the REPEAT_* parameters are absent.

## Test plan
Bench parameters: BLINK_HALF=4, REPEAT_DELAY=8, REPEAT_RATE=3.
- **Reset state:** reset, then release → `mode`=0, `blank`=0. `tick` pulse → `en_sec`=1 for 1 cycle; `en_min`=`en_hour`=0.
- **RUN carry ripple:** RUN with `tick`=1 and `done_sec`=`done_min`=`done_hour`=1 in the same cycle → `en_sec`, `en_min`, `en_hour`, `carry_day` all 1 in that cycle.
- **Mode cycle and edit:**
  - Four `btn_mode` presses → `mode` = 1, 2, 3, 0.
  - In SET_MIN, an `inc` press → `en_min`=1 for exactly 1 cycle. A concurrent `tick` and `done_sec` → `en_sec`=`en_hour`=0.
- **Blink:** in SET_HOUR with no presses → `blank` toggles 3'b000/3'b100 every 4 cycles. An `inc` press → `blank`=3'b000 for the next 4 cycles.
- **Edge cases:**
  - `btn_mode` and `btn_inc` rise in the same cycle while in SET_SEC → `mode`=0 and no enable asserted.
  - `btn_inc` held high through reset release → no pulse.
- **Auto-repeat (macro defined):** hold `btn_inc` 20 cycles in SET_SEC → `en_sec` pulses at cycles 0, 8, 11, 14, 17. Without the macro → a pulse at cycle 0 only.
